// File: rtl/intersections_seq.sv
// intersections_seq: multi-cycle circle-circle intersection engine.
// Takes one anchor pair (circle K, circle L) per transaction and produces both
// intersection points using exact integer arithmetic: a few wide products,
// one shared restoring square-root unit and one shared restoring divider.
//
// Handshake semantics (both ports): a transfer happens on the rising edge where
// valid && ready are both high. in_ready is high only in IDLE. out_valid is
// held with o/no_sol stable until the consumer raises out_ready. in_valid is
// ignored while the engine is busy.
module intersections_seq #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3*N:0]     g_input,
  input  logic [3*N:0]     e_input,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*N+7:0]   o,
  output logic             no_sol,
  output logic [2:0]       dbg_state
);

  // Working widths, chosen so no intermediate can overflow for any input.
  localparam int CW   = N + 1;        // dx, dy (signed)
  localparam int RW   = N + 1;        // radius (unsigned)
  localparam int DW   = 2 * N + 2;    // D and r^2 (unsigned)
  localparam int AW   = 2 * N + 4;    // A (signed)
  localparam int RRW  = 4 * N + 8;    // R (signed), also sqrt radicand shifter
  localparam int SW   = 2 * N + 4;    // S = floor(sqrt(R))
  localparam int SRW  = 2 * N + 5;    // sqrt partial remainder
  localparam int SCW  = SRW + 2;      // sqrt trial width
  localparam int NW   = 3 * N + 6;    // numerators (signed) / dividend magnitude
  localparam int DRW  = 2 * N + 3;    // divider remainder
  localparam int OW   = N + 2;        // each output coordinate
  localparam int CNTW = $clog2(NW + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RAD  = 3'd2,
    SQRT = 3'd3,
    DIV  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_next;

  // Captured inputs
  logic signed [N-1:0] xk_q, yk_q, xl_q, yl_q;
  logic [RW-1:0]       rk_q, rl_q;

  // Geometry registers
  logic signed [CW-1:0] dx_q, dy_q;
  logic [DW-1:0]        d_q, rk2_q;
  logic signed [AW-1:0] a_q;

  // Square-root unit
  logic [RRW-1:0] r_q;
  logic [SRW-1:0] sq_rem_q;
  logic [SW-1:0]  s_q;

  // Divider and sequencing
  logic [CNTW-1:0] cnt_q;
  logic [1:0]      idx_q;
  logic [DRW-1:0]  dv_rem_q;
  logic [NW-1:0]   dv_sh_q;
  logic [OW-1:0]   quot_q [4];

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // PREP arithmetic: deltas, squared distance, A = rK^2 - rL^2 + D
  // ---------------------------------------------------------------------------
  logic signed [CW-1:0] dx_c, dy_c;
  logic [DW-1:0]        dx_ext, dy_ext, dx_sq, dy_sq, d_c, rk2_c, rl2_c;
  logic signed [AW-1:0] a_c;

  assign dx_c   = {xl_q[N-1], xl_q} - {xk_q[N-1], xk_q};
  assign dy_c   = {yl_q[N-1], yl_q} - {yk_q[N-1], yk_q};
  assign dx_ext = {{(DW-CW){dx_c[CW-1]}}, dx_c};
  assign dy_ext = {{(DW-CW){dy_c[CW-1]}}, dy_c};
  assign dx_sq  = $signed(dx_ext) * $signed(dx_ext);
  assign dy_sq  = $signed(dy_ext) * $signed(dy_ext);
  assign d_c    = dx_sq + dy_sq;
  assign rk2_c  = {{(DW-RW){1'b0}}, rk_q} * {{(DW-RW){1'b0}}, rk_q};
  assign rl2_c  = {{(DW-RW){1'b0}}, rl_q} * {{(DW-RW){1'b0}}, rl_q};
  assign a_c    = $signed({2'b00, rk2_c}) - $signed({2'b00, rl2_c})
                + $signed({2'b00, d_c});

  // ---------------------------------------------------------------------------
  // RAD arithmetic: R = 4*rK^2*D - A^2; negative R or D == 0 has no solution
  // ---------------------------------------------------------------------------
  logic [RRW-1:0]        rkd_c, rkd4_c, a_ext;
  logic signed [RRW-1:0] a_sq, r_c;
  logic                  rad_fail;

  assign rkd_c    = {{(RRW-DW){1'b0}}, rk2_q} * {{(RRW-DW){1'b0}}, d_q};
  assign rkd4_c   = rkd_c << 2;
  assign a_ext    = {{(RRW-AW){a_q[AW-1]}}, a_q};
  assign a_sq     = $signed(a_ext) * $signed(a_ext);
  assign r_c      = $signed(rkd4_c) - a_sq;
  assign rad_fail = (d_q == '0) || r_c[RRW-1];

  // ---------------------------------------------------------------------------
  // Restoring square root: two radicand bits in, one root bit out per cycle
  // ---------------------------------------------------------------------------
  logic [SCW-1:0] sq_cur, sq_sub;
  logic           sq_ge, sq_last;

  assign sq_cur  = {sq_rem_q, r_q[RRW-1 -: 2]};
  assign sq_sub  = {{(SCW-SW-2){1'b0}}, s_q, 2'b01};
  assign sq_ge   = (sq_cur >= sq_sub);
  assign sq_last = (cnt_q == CNTW'(SW - 1));

  // ---------------------------------------------------------------------------
  // Numerators, selected in the order x1, y1, x2, y2
  // ---------------------------------------------------------------------------
  logic signed [NW-1:0] a_x, dx_x, dy_x, s_x;
  logic signed [NW-1:0] adx, ady, sdx, sdy, num_sel;
  logic [NW-1:0]        num_mag;
  logic                 num_neg;

  assign a_x  = {{(NW-AW){a_q[AW-1]}}, a_q};
  assign dx_x = {{(NW-CW){dx_q[CW-1]}}, dx_q};
  assign dy_x = {{(NW-CW){dy_q[CW-1]}}, dy_q};
  assign s_x  = {{(NW-SW){1'b0}}, s_q};
  assign adx  = a_x * dx_x;
  assign ady  = a_x * dy_x;
  assign sdx  = s_x * dx_x;
  assign sdy  = s_x * dy_x;

  // Pick the numerator for the division currently in progress
  always_comb begin
    num_sel = '0;
    case (idx_q)
      2'd0:    num_sel = adx - sdy;
      2'd1:    num_sel = ady + sdx;
      2'd2:    num_sel = adx + sdy;
      default: num_sel = ady - sdx;
    endcase
  end

  assign num_neg = num_sel[NW-1];
  assign num_mag = num_neg ? -num_sel : num_sel;

  // ---------------------------------------------------------------------------
  // Restoring divider on magnitudes; divisor is 2D, sign restored afterwards
  // ---------------------------------------------------------------------------
  logic [NW-1:0]  dv_src, dv_sh_n;
  logic [DRW-1:0] dv_base;
  logic [DRW:0]   dv_cur, dv_div;
  logic           dv_ge, dv_last;
  logic [OW-1:0]  q_mag_lo, q_lo;

  assign dv_src   = (cnt_q == '0) ? num_mag : dv_sh_q;
  assign dv_base  = (cnt_q == '0) ? '0 : dv_rem_q;
  assign dv_cur   = {dv_base, dv_src[NW-1]};
  assign dv_div   = {1'b0, d_q, 1'b0};
  assign dv_ge    = (dv_cur >= dv_div);
  assign dv_sh_n  = {dv_src[NW-2:0], dv_ge};
  assign dv_last  = (cnt_q == CNTW'(NW - 1));
  // Only the low output bits are kept; negating mod 2^OW equals truncating
  // the negated full-width quotient.
  assign q_mag_lo = dv_sh_n[OW-1:0];
  assign q_lo     = num_neg ? -q_mag_lo : q_mag_lo;

  // Final sums, truncated to the output width
  logic [OW-1:0] xk_x, yk_x, x1_s, y1_s, x2_s, y2_s;

  assign xk_x = {{(OW-N){xk_q[N-1]}}, xk_q};
  assign yk_x = {{(OW-N){yk_q[N-1]}}, yk_q};
  assign x1_s = xk_x + quot_q[0];
  assign y1_s = yk_x + quot_q[1];
  assign x2_s = xk_x + quot_q[2];
  assign y2_s = yk_x + quot_q[3];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = PREP;
      PREP:    state_next = RAD;
      RAD:     state_next = rad_fail ? DONE : SQRT;
      SQRT:    if (sq_last) state_next = DIV;
      DIV:     if (dv_last && (idx_q == 2'd3)) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xk_q      <= '0;
      yk_q      <= '0;
      xl_q      <= '0;
      yl_q      <= '0;
      rk_q      <= '0;
      rl_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      d_q       <= '0;
      rk2_q     <= '0;
      a_q       <= '0;
      r_q       <= '0;
      sq_rem_q  <= '0;
      s_q       <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      dv_rem_q  <= '0;
      dv_sh_q   <= '0;
      for (int i = 0; i < 4; i++) quot_q[i] <= '0;
      o         <= '0;
      out_valid <= 1'b0;
      no_sol    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xk_q   <= g_input[3*N -: N];
            yk_q   <= g_input[2*N -: N];
            rk_q   <= g_input[N:0];
            xl_q   <= e_input[3*N -: N];
            yl_q   <= e_input[2*N -: N];
            rl_q   <= e_input[N:0];
            no_sol <= 1'b0;
          end
        end
        PREP: begin
          dx_q  <= dx_c;
          dy_q  <= dy_c;
          d_q   <= d_c;
          a_q   <= a_c;
          rk2_q <= rk2_c;
        end
        RAD: begin
          r_q      <= r_c;
          sq_rem_q <= '0;
          s_q      <= '0;
          cnt_q    <= '0;
          idx_q    <= '0;
          if (rad_fail) no_sol <= 1'b1;
        end
        SQRT: begin
          r_q      <= r_q << 2;
          sq_rem_q <= SRW'(sq_ge ? (sq_cur - sq_sub) : sq_cur);
          s_q      <= {s_q[SW-2:0], sq_ge};
          cnt_q    <= sq_last ? '0 : cnt_q + 1'b1;
        end
        DIV: begin
          dv_rem_q <= DRW'(dv_ge ? (dv_cur - dv_div) : dv_cur);
          dv_sh_q  <= dv_sh_n;
          if (dv_last) begin
            quot_q[idx_q] <= q_lo;
            idx_q         <= idx_q + 1'b1;
            cnt_q         <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle forms the sums; then hold until released
          if (!out_valid) begin
            out_valid <= 1'b1;
            o         <= no_sol ? '0 : {x1_s, y1_s, x2_s, y2_s};
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intersections_seq.sv
// Directed bench for intersections_seq (N = 8).
module tb_intersections_seq;

  localparam int N       = 8;
  localparam int IW      = 3 * N + 1;
  localparam int OW      = 4 * N + 8;
  localparam int LAT_OK  = 14 * N + 31;
  localparam int LAT_NS  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [IW-1:0] g_input = '0;
  logic [IW-1:0] e_input = '0;
  logic          in_ready, out_valid, no_sol;
  logic [OW-1:0] o;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  intersections_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g_input   (g_input),
    .e_input   (e_input),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .no_sol    (no_sol),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Safety net against a hung DUT
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [IW-1:0] circ(input int x, input int y, input int r);
    logic [N-1:0] xs, ys;
    logic [N:0]   rs;
    xs = x[N-1:0];
    ys = y[N-1:0];
    rs = r[N:0];
    return {xs, ys, rs};
  endfunction

  function automatic logic [OW-1:0] pts(input int x1, input int y1, input int x2, input int y2);
    logic [N+1:0] a, b, c, d;
    a = x1[N+1:0];
    b = y1[N+1:0];
    c = x2[N+1:0];
    d = y2[N+1:0];
    return {a, b, c, d};
  endfunction

  // Count edges after the accept edge until out_valid is seen; -1 if never
  task automatic wait_valid(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic send(input string tag, input logic [IW-1:0] g, input logic [IW-1:0] e);
    check({tag, " in_ready idle"}, 64'(in_ready), 64'(1));
    g_input  = g;
    e_input  = e;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " in_ready busy"}, 64'(in_ready), 64'(0));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after release"}, 64'(out_valid), 64'(0));
    check({tag, " in_ready after release"}, 64'(in_ready), 64'(1));
  endtask

  task automatic run_case(input string tag, input logic [IW-1:0] g, input logic [IW-1:0] e,
                          input logic [OW-1:0] want_o, input logic want_ns, input int want_lat);
    int lat;
    send(tag, g, e);
    wait_valid(want_lat + 20, lat);
    check({tag, " latency"}, 64'(lat), 64'(want_lat));
    check({tag, " o"}, 64'(o), 64'(want_o));
    check({tag, " no_sol"}, 64'(no_sol), 64'(want_ns));
    release_out(tag);
  endtask

  initial begin
    int lat;
    int phantom;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'(1));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset o", 64'(o), 64'(0));
    check("reset no_sol", 64'(no_sol), 64'(0));
    check("reset state idle", 64'(dbg_state), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Valid geometry
    run_case("basic",    circ(0, 0, 5),   circ(6, 0, 5),   pts(3, 4, 3, -4),  1'b0, LAT_OK);
    run_case("tangent",  circ(0, 0, 3),   circ(6, 0, 3),   pts(3, 0, 3, 0),   1'b0, LAT_OK);
    run_case("trunc",    circ(0, 0, 4),   circ(5, 0, 4),   pts(2, 3, 2, -3),  1'b0, LAT_OK);
    run_case("vertical", circ(0, 0, 5),   circ(0, 6, 5),   pts(-4, 3, 4, 3),  1'b0, LAT_OK);
    run_case("diagonal", circ(0, 0, 5),   circ(7, 1, 5),   pts(3, 4, 4, -3),  1'b0, LAT_OK);
    run_case("radii",    circ(0, 0, 5),   circ(4, 0, 3),   pts(4, 3, 4, -3),  1'b0, LAT_OK);
    run_case("negative", circ(-3, -3, 5), circ(3, -3, 5),  pts(0, 1, 0, -7),  1'b0, LAT_OK);

    // No-solution cases (o must be cleared after the previous nonzero result)
    run_case("disjoint",   circ(0, 0, 2), circ(10, 0, 2), '0, 1'b1, LAT_NS);
    run_case("concentric", circ(3, 3, 4), circ(3, 3, 6),  '0, 1'b1, LAT_NS);

    // Backpressure with an ignored in_valid pulse
    send("bp", circ(0, 0, 5), circ(6, 0, 5));
    wait_valid(LAT_OK + 20, lat);
    check("bp latency", 64'(lat), 64'(LAT_OK));
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        g_input  = circ(0, 0, 4);
        e_input  = circ(5, 0, 4);
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp o stable", 64'(o), 64'(pts(3, 4, 3, -4)));
      check("bp out_valid held", 64'(out_valid), 64'(1));
      check("bp in_ready low", 64'(in_ready), 64'(0));
    end
    release_out("bp");
    phantom = 0;
    repeat (LAT_OK + 20) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) phantom++;
    end
    check("bp pulse not accepted", 64'(phantom), 64'(0));

    // Asynchronous reset during SQRT
    send("rst", circ(0, 0, 5), circ(6, 0, 5));
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst in_ready", 64'(in_ready), 64'(1));
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst o cleared", 64'(o), 64'(0));
    check("rst no_sol", 64'(no_sol), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    phantom = 0;
    repeat (LAT_OK + 20) begin
      @(posedge clk); #1;
      if (out_valid) phantom++;
    end
    check("rst no output", 64'(phantom), 64'(0));
    run_case("after_rst", circ(0, 0, 5), circ(6, 0, 5), pts(3, 4, 3, -4), 1'b0, LAT_OK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
